pipe_stage_reg: RTL
===================

// Module: pipe_stage_reg
// PURPOSE
//  Parametrised inter-stage pipeline register (E/M, M/W) for the 5-stage MIPS core with CP0.
//  Latches a generic payload plus hazard/exception sideband, counts Tnew down, and merges this stage's exception.
//  Supports hold (stall), flush (interrupt/exception), bubble insertion and a valid bit.
//  Publishes a forwarding-ready flag to the hazard unit.
// PARAMETERS
//  DATA_W    96  payload width (e.g. ExeResult, RD2, PCNxt)
//  CTRL_W    12  control-bus width (MemWrite, MemType, RegDataSrc, CP0WE, EXLClr, isIDS ...)
//  TNEW_W    4   Tnew/TuseM counter width
//  EXC_W     5   exception code width; EXC_NONE = 0
//  KILL_EXC  1   1: an excepting instruction leaves with RegWrite=0 and CTRL masked by CTRL_KILL
//  CTRL_KILL 0   CTRL value forced on bubble/flush/kill (all-zero = NOP controls)
// PORTS
//  clk         in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low reset
//  en          in   1       1: stage advances this cycle; 0: hold contents
//  flush       in   1       requestInt / exception flush; load NOP
//  bubble      in   1       upstream stalled; load NOP instead of inputs
//  data_in     in   DATA_W  payload from previous stage
//  ctrl_in     in   CTRL_W  control bus
//  reg_we_in   in   1       RegWrite
//  a1_in/a2_in/a3_in in 5   register addresses
//  tnew_in     in   TNEW_W  cycles until result ready, counted at previous stage
//  tusem_in    in   TNEW_W  TuseM
//  exc_in      in   EXC_W   exception carried from earlier stages
//  new_exc     in   1       exception raised in the stage feeding this register
//  new_exc_code in  EXC_W   its code
//  data_out/ctrl_out/reg_we_out/a1_out/a2_out/a3_out/tusem_out  out  widths as inputs
//  tnew_out    out  TNEW_W  decremented Tnew
//  exc_out     out  EXC_W   merged exception code
//  valid_out   out  1       1 = real instruction, 0 = bubble
//  fwd_rdy     out  1       valid_out & reg_we_out & a3_out!=0 & tnew_out==0
// BEHAVIOUR
//  - Reset (reset=0, async): all outputs 0; ctrl_out=CTRL_KILL; exc_out=EXC_NONE; valid_out=0.
//  - Priority per posedge: flush > !en (hold) > bubble > load.
//  - flush=1: load NOP regardless of en; valid=0, reg_we=0, addrs=0, tnew=0, exc=NONE, data=0.
//  - en=0, flush=0: every output holds; tnew NOT decremented.
//  - bubble=1 (en=1): same NOP load as flush.
//  - load: all fields copied; valid_out<=1.
//  - tnew_out <= (tnew_in==0) ? 0 : tnew_in-1 (unsigned saturating, no wrap).
//  - exc_out <= (exc_in!=NONE) ? exc_in : (new_exc ? new_exc_code : NONE); older exception wins.
//  - KILL_EXC=1 and merged exc!=NONE: reg_we_out<=0, ctrl_out<=CTRL_KILL; data/PC still latched (EPC needs PC).
//  - new_exc ignored on bubble/flush/hold.
//  - One cycle latency input->output; fwd_rdy combinational from registered outputs.
//  - Reset deasserted mid-stream: first edge after release loads normally.
// TESTING
//  1 reset=0 mid-run with valid data -> all outputs 0 immediately (before next edge), valid_out=0.
//  2 load tnew_in=2, a3=8, we=1 -> tnew_out=1, fwd_rdy=0; next load tnew_in=0 -> tnew_out=0, fwd_rdy=1.
//  3 en=0 for 3 cycles after load data=0xDEAD -> outputs stable at 0xDEAD, tnew unchanged.
//  4 en=0 & flush=1 -> NOP next edge (flush beats hold); bubble=1 -> valid_out=0, reg_we_out=0.
//  5 exc_in=4 & new_exc=1 code=12 -> exc_out=4; exc_in=0 & new_exc code=12 -> exc_out=12, reg_we_out=0 (KILL_EXC=1).
//  6 a3_in=0, we=1, tnew=0 -> fwd_rdy=0; sweep DATA_W=32/96 builds, same results.

Source files
------------

// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between a pipeline stage and its inter-stage register.
// The master side (the stage and hazard unit) drives the controls and payload. The slave side is the register.
interface pipe_stage_reg_if #(
   parameter int DATA_W = 96,
   parameter int CTRL_W = 12,
   parameter int TNEW_W = 4,
   parameter int EXC_W  = 5
);
   logic              en;
   logic              flush;
   logic              bubble;
   logic [DATA_W-1:0] data_in;
   logic [CTRL_W-1:0] ctrl_in;
   logic              reg_we_in;
   logic [4:0]        a1_in, a2_in, a3_in;
   logic [TNEW_W-1:0] tnew_in;
   logic [TNEW_W-1:0] tusem_in;
   logic [EXC_W-1:0]  exc_in;
   logic              new_exc;
   logic [EXC_W-1:0]  new_exc_code;

   logic [DATA_W-1:0] data_out;
   logic [CTRL_W-1:0] ctrl_out;
   logic              reg_we_out;
   logic [4:0]        a1_out, a2_out, a3_out;
   logic [TNEW_W-1:0] tnew_out;
   logic [TNEW_W-1:0] tusem_out;
   logic [EXC_W-1:0]  exc_out;
   logic              valid_out;
   logic              fwd_rdy;

   modport master (
      output en, flush, bubble, data_in, ctrl_in, reg_we_in, a1_in, a2_in, a3_in,
             tnew_in, tusem_in, exc_in, new_exc, new_exc_code,
      input  data_out, ctrl_out, reg_we_out, a1_out, a2_out, a3_out, tnew_out,
             tusem_out, exc_out, valid_out, fwd_rdy
   );

   modport slave (
      input  en, flush, bubble, data_in, ctrl_in, reg_we_in, a1_in, a2_in, a3_in,
             tnew_in, tusem_in, exc_in, new_exc, new_exc_code,
      output data_out, ctrl_out, reg_we_out, a1_out, a2_out, a3_out, tnew_out,
             tusem_out, exc_out, valid_out, fwd_rdy
   );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register (E/M, M/W). It holds on stall, loads a NOP on flush or bubble,
// counts Tnew down, merges this stage's exception, and flags when a result can be forwarded.
module pipe_stage_reg #(
   parameter int              DATA_W    = 96,
   parameter int              CTRL_W    = 12,
   parameter int              TNEW_W    = 4,
   parameter int              EXC_W     = 5,
   parameter bit              KILL_EXC  = 1'b1,
   parameter logic [CTRL_W-1:0] CTRL_KILL = '0
) (
   input logic             clk,
   input logic             reset,
   pipe_stage_reg_if.slave bus
);
   localparam logic [EXC_W-1:0] EXC_NONE = '0;

   logic [DATA_W-1:0] r_data;
   logic [CTRL_W-1:0] r_ctrl;
   logic              r_we;
   logic [4:0]        r_a1, r_a2, r_a3;
   logic [TNEW_W-1:0] r_tnew;
   logic [TNEW_W-1:0] r_tusem;
   logic [EXC_W-1:0]  r_exc;
   logic              r_valid;

   logic [EXC_W-1:0]  w_exc;
   logic              w_kill;
   logic [TNEW_W-1:0] w_tnew;

   // An exception from an older stage wins over one raised here.
   assign w_exc  = (bus.exc_in != EXC_NONE) ? bus.exc_in
                 : (bus.new_exc ? bus.new_exc_code : EXC_NONE);
   assign w_kill = KILL_EXC && (w_exc != EXC_NONE);
   assign w_tnew = (bus.tnew_in == '0) ? '0 : bus.tnew_in - TNEW_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data  <= '0;
         r_ctrl  <= CTRL_KILL;
         r_we    <= 1'b0;
         r_a1    <= '0;
         r_a2    <= '0;
         r_a3    <= '0;
         r_tnew  <= '0;
         r_tusem <= '0;
         r_exc   <= EXC_NONE;
         r_valid <= 1'b0;
      end else if (bus.flush || (bus.en && bus.bubble)) begin
         r_data  <= '0;
         r_ctrl  <= CTRL_KILL;
         r_we    <= 1'b0;
         r_a1    <= '0;
         r_a2    <= '0;
         r_a3    <= '0;
         r_tnew  <= '0;
         r_tusem <= '0;
         r_exc   <= EXC_NONE;
         r_valid <= 1'b0;
      end else if (bus.en) begin
         // A killed instruction keeps its payload so the handler still sees its PC for EPC.
         r_data  <= bus.data_in;
         r_ctrl  <= w_kill ? CTRL_KILL : bus.ctrl_in;
         r_we    <= bus.reg_we_in && !w_kill;
         r_a1    <= bus.a1_in;
         r_a2    <= bus.a2_in;
         r_a3    <= bus.a3_in;
         r_tnew  <= w_tnew;
         r_tusem <= bus.tusem_in;
         r_exc   <= w_exc;
         r_valid <= 1'b1;
      end
   end

   assign bus.data_out   = r_data;
   assign bus.ctrl_out   = r_ctrl;
   assign bus.reg_we_out = r_we;
   assign bus.a1_out     = r_a1;
   assign bus.a2_out     = r_a2;
   assign bus.a3_out     = r_a3;
   assign bus.tnew_out   = r_tnew;
   assign bus.tusem_out  = r_tusem;
   assign bus.exc_out    = r_exc;
   assign bus.valid_out  = r_valid;
   assign bus.fwd_rdy    = r_valid && r_we && (r_a3 != 5'd0) && (r_tnew == '0);
endmodule
